// File: rtl/memory_cycle.sv
// Memory stage of the 5-stage RISC-V pipeline: byte/half/word loads and stores with a
// configurable-latency data array, upstream stall, and the MEM/WB pipeline register.
module memory_cycle #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] LatInit = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    typedef enum logic {StIdle, StWait} stateT;

    stateT       stateQ, stateD;
    logic [3:0]  cntQ, cntD;

    logic [31:0] mem [DEPTH];

    logic          access, illegal, misalign, bad, doWrite;
    logic [AW-1:0] wordIdx;
    logic [31:0]   rdWord, loadData, wrData;
    logic [7:0]    selByte;
    logic [15:0]   selHalf;
    logic [3:0]    byteEn;

    assign access  = MemWriteM | ResultSrcM;
    assign wordIdx = ALU_ResultM[AW+1:2];
    assign rdWord  = mem[wordIdx];
    assign selByte = 8'(rdWord >> {ALU_ResultM[1:0], 3'b000});
    assign selHalf = 16'(rdWord >> {ALU_ResultM[1], 4'b0000});

    // Width/sign decode: lane enables and replicated store data, extended load data.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        byteEn   = 4'b0000;
        wrData   = WriteDataM;
        loadData = 32'h0;
        case (Funct3M)
            3'b000: begin
                byteEn   = 4'b0001 << ALU_ResultM[1:0];
                wrData   = {4{WriteDataM[7:0]}};
                loadData = {{24{selByte[7]}}, selByte};
            end
            3'b100: begin
                illegal  = MemWriteM;
                loadData = {24'h0, selByte};
            end
            3'b001: begin
                misalign = ALU_ResultM[0];
                byteEn   = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                wrData   = {2{WriteDataM[15:0]}};
                loadData = {{16{selHalf[15]}}, selHalf};
            end
            3'b101: begin
                illegal  = MemWriteM;
                misalign = ALU_ResultM[0];
                loadData = {16'h0, selHalf};
            end
            3'b010: begin
                misalign = ALU_ResultM[1:0] != 2'b00;
                byteEn   = 4'b1111;
                loadData = rdWord;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bad = access & (illegal | misalign);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        StallM = 1'b0;
        case (stateQ)
            StIdle: begin
                if (access && !bad && (MEM_LATENCY > 0)) begin
                    StallM = 1'b1;
                    cntD   = LatInit;
                    stateD = StWait;
                end
            end
            StWait: begin
                if (cntQ != 4'd0) begin
                    StallM = 1'b1;
                    cntD   = cntQ - 4'd1;
                end else begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        if (rst) StallM = 1'b0;
    end

    assign doWrite = !rst && !StallM && MemWriteM && !bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'h0;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
            MisalignW   <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~bad;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (ResultSrcM && !bad) ? loadData : 32'h0;
            MisalignW   <= bad;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: one zero-latency and one 3-cycle-latency instance
// share the same upstream inputs.
module tb_memory_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    logic        stall0, regWriteW0, resultSrcW0, misW0;
    logic [4:0]  rdW0;
    logic [31:0] pcW0, aluW0, readW0;
    logic        stall3, regWriteW3, resultSrcW3, misW3;
    logic [4:0]  rdW3;
    logic [31:0] pcW3, aluW3, readW3;

    int vectors = 0;
    int miscompares = 0;
    bit stallSeen0;

    memory_cycle #(.DEPTH(1024), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(stall0),
        .RegWriteW(regWriteW0), .ResultSrcW(resultSrcW0), .RD_W(rdW0), .PCPlus4W(pcW0),
        .ALU_ResultW(aluW0), .ReadDataW(readW0), .MisalignW(misW0)
    );

    memory_cycle #(.DEPTH(1024), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(stall3),
        .RegWriteW(regWriteW3), .ResultSrcW(resultSrcW3), .RD_W(rdW3), .PCPlus4W(pcW3),
        .ALU_ResultW(aluW3), .ReadDataW(readW3), .MisalignW(misW3)
    );

    always @(negedge clk) if (!rst && stall0) stallSeen0 = 1'b1;

    task automatic setOp(input logic rw, input logic mw, input logic rs, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        Funct3M     = f3;
        RD_M        = rd;
        ALU_ResultM = addr;
        WriteDataM  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the presented op on dut3 until a non-stalled edge (bounded to 10 cycles).
    task automatic runOp3(output int stalls, output bit bubbleOk);
        bit done = 1'b0;
        bit s;
        stalls   = 0;
        bubbleOk = 1'b1;
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            s = stall3;
            @(posedge clk);
            #1;
            if (!s) done = 1'b1;
            else begin
                stalls++;
                if (regWriteW3 !== 1'b0 || misW3 !== 1'b0) bubbleOk = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        PCPlus4M = 32'h0;
        setOp(1, 0, 1, 3'b010, 5'd1, 32'h0, 32'h0);
        tick();
        tick();
        vectors++;
        if ({regWriteW0, resultSrcW0, rdW0, pcW0, aluW0, readW0, misW0} !== '0) begin
            miscompares++;
            $display("FAIL reset_w0: got %0h want 0",
                     {regWriteW0, resultSrcW0, rdW0, pcW0, aluW0, readW0, misW0});
        end
        vectors++;
        if ({regWriteW3, resultSrcW3, rdW3, pcW3, aluW3, readW3, misW3} !== '0) begin
            miscompares++;
            $display("FAIL reset_w3: got %0h want 0",
                     {regWriteW3, resultSrcW3, rdW3, pcW3, aluW3, readW3, misW3});
        end
        vectors++;
        if (stall3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall3: got %b want 0", stall3);
        end
        setOp(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_word();
        stallSeen0 = 1'b0;
        setOp(0, 1, 0, 3'b010, 5'd0, 32'h10, 32'hDEADBEEF);
        tick();
        setOp(1, 0, 1, 3'b010, 5'd5, 32'h10, 32'h0);
        tick();
        vectors++;
        if (readW0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_data: got %h want deadbeef", readW0);
        end
        vectors++;
        if ({regWriteW0, rdW0, misW0} !== {1'b1, 5'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_ctrl: got rw=%b rd=%0d mis=%b want 1/5/0", regWriteW0, rdW0, misW0);
        end
        vectors++;
        if (stallSeen0 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat0_stall: got %b want 0", stallSeen0);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            setOp(1, 0, 1, f3s[i], 5'd6, addrs[i], 32'h0);
            tick();
            vectors++;
            if (readW0 !== exps[i]) begin
                miscompares++;
                $display("FAIL load_ext[%0d]: got %h want %h", i, readW0, exps[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        setOp(0, 1, 0, 3'b000, 5'd0, 32'h11, 32'h00000055);
        tick();
        setOp(1, 0, 1, 3'b010, 5'd2, 32'h10, 32'h0);
        tick();
        vectors++;
        if (readW0 !== 32'hDEAD55EF) begin
            miscompares++;
            $display("FAIL sb_merge: got %h want dead55ef", readW0);
        end
    endtask

    task automatic test_misalign();
        stallSeen0 = 1'b0;
        setOp(1, 0, 1, 3'b010, 5'd3, 32'h12, 32'h0);
        tick();
        vectors++;
        if ({misW0, regWriteW0, readW0} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL lw_mis: got mis=%b rw=%b rd=%h want 1/0/0", misW0, regWriteW0, readW0);
        end
        setOp(0, 1, 0, 3'b001, 5'd0, 32'h11, 32'h0000FFFF);
        tick();
        vectors++;
        if (misW0 !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_mis: got %b want 1", misW0);
        end
        setOp(0, 1, 0, 3'b100, 5'd0, 32'h10, 32'h00000077);
        tick();
        vectors++;
        if (misW0 !== 1'b1) begin
            miscompares++;
            $display("FAIL sbu_illegal: got %b want 1", misW0);
        end
        setOp(1, 0, 1, 3'b010, 5'd4, 32'h10, 32'h0);
        tick();
        vectors++;
        if ({readW0, misW0, regWriteW0} !== {32'hDEAD55EF, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL bad_nowrite: got %h mis=%b rw=%b want dead55ef/0/1",
                     readW0, misW0, regWriteW0);
        end
        vectors++;
        if (stallSeen0 !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_stall: got %b want 0", stallSeen0);
        end
    endtask

    task automatic test_alu_pass();
        setOp(1, 0, 0, 3'b000, 5'd7, 32'h00001234, 32'hFFFFFFFF);
        PCPlus4M = 32'h44;
        tick();
        vectors++;
        if ({regWriteW0, resultSrcW0, rdW0, aluW0, pcW0, readW0} !==
            {1'b1, 1'b0, 5'd7, 32'h1234, 32'h44, 32'h0}) begin
            miscompares++;
            $display("FAIL alu_pass0: got rw=%b rs=%b rd=%0d alu=%h pc=%h rdat=%h",
                     regWriteW0, resultSrcW0, rdW0, aluW0, pcW0, readW0);
        end
    endtask

    task automatic test_latency();
        int stalls;
        bit bubbleOk;
        rst = 1'b1;
        setOp(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        setOp(0, 1, 0, 3'b010, 5'd0, 32'h20, 32'hCAFEF00D);
        runOp3(stalls, bubbleOk);
        vectors++;
        if (stalls !== 3 || !bubbleOk) begin
            miscompares++;
            $display("FAIL sw_lat3: got stalls=%0d bubble=%b want 3/1", stalls, bubbleOk);
        end
        setOp(1, 0, 1, 3'b010, 5'd9, 32'h20, 32'h0);
        runOp3(stalls, bubbleOk);
        vectors++;
        if (stalls !== 3 || !bubbleOk) begin
            miscompares++;
            $display("FAIL lw_lat3_stall: got stalls=%0d bubble=%b want 3/1", stalls, bubbleOk);
        end
        vectors++;
        if ({readW3, regWriteW3, rdW3} !== {32'hCAFEF00D, 1'b1, 5'd9}) begin
            miscompares++;
            $display("FAIL lw_lat3_data: got %h rw=%b rd=%0d want cafef00d/1/9",
                     readW3, regWriteW3, rdW3);
        end
        setOp(1, 0, 0, 3'b000, 5'd8, 32'h55, 32'h0);
        #1;
        vectors++;
        if (stall3 !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_lat3_stall: got %b want 0", stall3);
        end
        tick();
        vectors++;
        if ({regWriteW3, rdW3, aluW3} !== {1'b1, 5'd8, 32'h55}) begin
            miscompares++;
            $display("FAIL alu_lat3: got rw=%b rd=%0d alu=%h want 1/8/55", regWriteW3, rdW3, aluW3);
        end
    endtask

    task automatic test_reset_mid();
        int stalls;
        bit bubbleOk;
        setOp(0, 1, 0, 3'b010, 5'd0, 32'h20, 32'h12345678);
        tick();
        #1;
        vectors++;
        if (stall3 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wait: got %b want 1", stall3);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (stall3 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_stall: got %b want 0", stall3);
        end
        tick();
        vectors++;
        if ({regWriteW3, resultSrcW3, rdW3, pcW3, aluW3, readW3, misW3, stall3} !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_w: got %0h want 0",
                     {regWriteW3, resultSrcW3, rdW3, pcW3, aluW3, readW3, misW3, stall3});
        end
        rst = 1'b0;
        setOp(1, 0, 1, 3'b010, 5'd10, 32'h20, 32'h0);
        runOp3(stalls, bubbleOk);
        vectors++;
        if ({readW3, regWriteW3} !== {32'hCAFEF00D, 1'b1} || stalls !== 3) begin
            miscompares++;
            $display("FAIL mid_nowrite: got %h rw=%b stalls=%0d want cafef00d/1/3",
                     readW3, regWriteW3, stalls);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_loads();
        test_byte_store();
        test_misalign();
        test_alu_pass();
        test_latency();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
Memory stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline outputs of the execute stage and performs the data-memory access. Supported accesses are byte, half and word loads and stores, with load sign/zero extension and misalignment detection. Access latency is configurable; the stage stalls upstream while an access is outstanding. It registers the results into the MEM/WB pipeline register for writeback.

Parameters:
DEPTH, 1024, data memory size in 32-bit words (power of 2).
MEM_LATENCY, 0, extra wait cycles per memory access (0..15); an access occupies MEM_LATENCY+1 cycles.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
RegWriteM  input  1  register write enable from EX/MEM
MemWriteM  input  1  store
ResultSrcM  input  1  1 = load (writeback selects memory data), 0 = ALU result
Funct3M  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
RD_M  input  5  destination register
PCPlus4M  input  32  PC+4
WriteDataM  input  32  store data
ALU_ResultM  input  32  effective address / ALU result
StallM  output  1  high = hold EX/MEM inputs stable; upstream must not advance
RegWriteW  output  1  registered write enable
ResultSrcW  output  1  registered result select
RD_W  output  5  registered destination
PCPlus4W  output  32  registered PC+4
ALU_ResultW  output  32  registered ALU result
ReadDataW  output  32  registered, extended load data
MisalignW  output  1  registered misaligned/illegal-access flag

Behaviour:
- Reset, on a clk edge with rst=1: all W outputs become 0, FSM goes to IDLE, wait counter becomes 0. StallM is 0 while rst=1. Memory contents are NOT cleared.
- Access definition: access = MemWriteM | ResultSrcM.
- Address mapping: word index = ALU_ResultM[log2(DEPTH)+1:2]. Higher bits are ignored, so addresses wrap modulo DEPTH*4.
- Bad access: the access is misaligned when it is a half with addr[0]=1 or a word with addr[1:0]≠0. Funct3 values other than 000/001/010/100/101 on an access are illegal. Stores with funct3 100/101 are also illegal.
  - A bad access performs no memory write and takes no wait states (completes in 1 cycle).
  - It registers MisalignW=1 and RegWriteW=0.
- Stores:
  - Byte-lane write enables: SB writes lane addr[1:0] from WriteDataM[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} from WriteDataM[15:0]. SW writes all 4 lanes.
  - The write happens once, on the completing edge only.
- Loads:
  - Reading is combinational from the array, on the completing cycle.
  - The selected byte or half is sign-extended (B, H) or zero-extended (BU, HU) and captured into ReadDataW.
  - A load that immediately follows a store to the same word returns the new data.
- FSM, states IDLE and WAIT, with a 4-bit counter cnt:
  - IDLE, access valid, MEM_LATENCY>0: StallM=1, cnt<=MEM_LATENCY-1, go to WAIT.
  - IDLE with no access, MEM_LATENCY=0, or a bad access: StallM=0; the instruction completes this cycle.
  - WAIT, cnt≠0: StallM=1, cnt<=cnt-1.
  - WAIT, cnt=0: StallM=0; the access completes; go to IDLE.
- MEM/WB register:
  - On a completing edge, it captures RegWriteM (forced to 0 if bad), ResultSrcM, RD_M, PCPlus4M, ALU_ResultM, the extended read data and the misalign flag.
  - On a stalled edge (StallM=1), it loads a bubble: RegWriteW=0 and MisalignW=0, other fields don't-care.
  - For a non-load, ReadDataW is 0.
- Reset mid-access (rst during WAIT): the FSM returns to IDLE, no write occurs and outputs are zeroed.
- Upstream contract: upstream holds all M inputs stable while StallM=1. Behaviour is undefined if they change.
- Latency: W outputs are valid 1 cycle after completion. Total latency from input presentation is MEM_LATENCY+1 cycles.

Test Plan:
- MEM_LATENCY=0: SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 with RD_M=5. Required: ReadDataW=0xDEADBEEF, RegWriteW=1, RD_W=5, StallM never asserted.
- After the above: LB addr 0x13 -> ReadDataW=0xFFFFFFDE. LBU addr 0x13 -> 0x000000DE. LH addr 0x10 -> 0xFFFFBEEF. LHU addr 0x12 -> 0x0000DEAD.
- Byte store: SB 0x55 to addr 0x11, then LW 0x10. Required: ReadDataW=0xDEAD55EF.
- Misaligned accesses:
  - LW at 0x12 with RegWriteM=1: MisalignW=1, RegWriteW=0.
  - SH at 0x11: no memory change (a following LW 0x10 is unchanged), no stall.
- MEM_LATENCY=3, LW:
  - StallM=1 for exactly 3 cycles with bubble W outputs (RegWriteW=0).
  - The data appears on the 4th edge.
  - A non-access ALU op passes through in 1 cycle with StallM=0.
- MEM_LATENCY=3: SW 0x12345678 to 0x20, assert rst in the 2nd stall cycle. Required: StallM=0 and all W outputs 0 after that edge; a following LW 0x20 returns the prior contents (no write occurred).
